counter_ctrl: RTL

Sequencing controller for the team's binary counters: accepts start/stop/pause commands, runs an internal up-counter from 0 to a programmed terminal value, and signals completion with a one-cycle done pulse. It supports one-shot and auto-reload (periodic) modes. It sits between the control logic and the count datapath, replacing free-running ripple chains where software-visible sequencing is needed.

---
 rtl/counter_ctrl_pkg.sv | 13 +
 rtl/counter_ctrl_sync_up_counter.sv | 27 ++
 rtl/counter_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizing for the counter_ctrl sequencing block.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH    = 4;
  localparam int unsigned DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/counter_ctrl_sync_up_counter.sv
// Plain synchronous up-counter with clear and enable; clear beats enable.
module sync_up_counter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: reset/clear to zero, otherwise step by one when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause sequencer around a synchronous up-counter,
// one-shot or auto-reload, with a one-cycle done pulse at terminal count.
// Optional tick prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
    $error("counter_ctrl: WIDTH and PRESCALE must both be at least 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cnt_clr, cnt_en;
  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] cnt;

  sync_up_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .q  (cnt)
  );

  assign at_term = (cnt == term_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  // Prescaler next value: cleared on start, advances only on active RUN cycles.
  always_comb begin
    pre_d = pre_q;
    if (state_q == IDLE && start && !stop) begin
      pre_d = '0;
    end else if (state_q == RUN && !stop && !pause) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state, counter control and done/busy generation.
  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          term_d   = load_val;
          reload_d = auto_reload;
          cnt_clr  = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end else if (tick) begin
          if (at_term) begin
            done_d = 1'b1;
            if (reload_q) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      term_q   <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      term_q   <= term_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign q    = cnt;
  assign busy = busy_q;
  assign done = done_q;

endmodule
